// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read per accepted PC, {pc, instr} queued for decode.
// Min latency pc accept -> instr_valid is 3 cycles; pc_ready drops while busy or when no FIFO slot can be reserved.
module instr_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              flush,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                flush_pend_q, flush_pend_d;

  logic [DATA_W-1:0]   dat_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                push;
  logic                pop;

  // A slot is reserved at acceptance, so the later push can never overflow.
  assign pc_ready    = (state_q == IDLE) && (count_q < DEPTH_C) && !flush;
  assign imem_addr   = {pc_q[ADDR_W-1:2], 2'b00};
  assign instr_valid = (count_q != '0);
  assign instr_out   = dat_mem_q[head_q];
  assign instr_pc    = pc_mem_q[head_q];
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flush_pend_d   = flush_pend_q;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_valid && pc_ready) begin
          pc_d         = pc_in;
          flush_pend_d = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        // The request is never withdrawn; a flush only marks the response for discard.
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d      = (flush || flush_pend_q) ? DRAIN : WAIT;
          flush_pend_d = 1'b0;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push    = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      flush_pend_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dat_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_pend_q <= flush_pend_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      if (push && !flush) begin
        dat_mem_q[tail_q] <= imem_rsp_data;
        pc_mem_q[tail_q]  <= pc_q;
      end
    end
  end

  a_rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (state_q == WAIT || state_q == DRAIN));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    push |-> (count_q < DEPTH_C || pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          flush;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;

  int checks = 0;
  int errors = 0;

  int            mem_extra   = 0;
  logic          mem_fixed_en = 1'b0;
  logic [DW-1:0] mem_fixed   = '0;
  logic          mem_rand    = 1'b0;
  logic          mem_pend    = 1'b0;
  int            mem_cnt     = 0;
  logic [DW-1:0] mem_dat     = '0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] dat;
  } ent_t;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  // Instruction memory: answers each accepted request mem_extra+1 cycles later; shares reset.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (!reset) begin
        mem_pend = 1'b0;
      end else begin
        if (mem_pend) begin
          if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_dat;
            mem_pend       = 1'b0;
          end else begin
            mem_cnt--;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          mem_pend = 1'b1;
          mem_cnt  = mem_extra;
          if (mem_fixed_en)  mem_dat = mem_fixed;
          else if (mem_rand) mem_dat = $urandom;
          else               mem_dat = 32'hAAAA0000 + imem_addr;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    reset          = 1'b0;
    pc_valid       = 1'b0;
    pc_in          = '0;
    flush          = 1'b0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    mem_extra      = 0;
    mem_fixed_en   = 1'b0;
    mem_rand       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_valid = 1'b0; pc_in = '0; flush = 1'b0;
    instr_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h want 0", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL reset_pc_ready: got %b want 1", pc_ready); end
    pc_valid = 1'b1;
    pc_in    = 32'h0;
    @(negedge clk);
    pc_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b want 1", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_addr: got %h want 0", imem_addr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_streaming();
    int idx;
    int nval;
    int c0;
    logic [AW-1:0] exp_pc;
    apply_reset();
    idx = 0; nval = 0; c0 = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      pc_valid = (idx < 3);
      pc_in    = 32'(idx * 4);
      #1;
      if (instr_valid) begin
        exp_pc = 32'(nval * 4);
        checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h want %h", instr_pc, exp_pc); end
        checks++; if (instr_out !== 32'hAAAA0000 + exp_pc) begin errors++; $display("FAIL stream_data: got %h want %h", instr_out, 32'hAAAA0000 + exp_pc); end
        checks++; if (cyc !== c0 + 3 + 3 * nval) begin errors++; $display("FAIL stream_timing: got cycle %0d want %0d", cyc, c0 + 3 + 3 * nval); end
        nval++;
      end
      if (pc_valid && pc_ready) begin
        if (idx == 0) c0 = cyc;
        idx++;
      end
      @(negedge clk);
    end
    pc_valid = 1'b0;
    checks++; if (nval !== 3) begin errors++; $display("FAIL stream_count: got %0d pulses want 3", nval); end
  endtask

  task automatic test_backpressure();
    int idx;
    apply_reset();
    instr_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 2; cyc++) begin
      pc_valid = 1'b1;
      pc_in    = (idx == 0) ? 32'h10 : 32'h14;
      #1;
      if (pc_ready) idx++;
      @(negedge clk);
    end
    pc_valid = 1'b0;
    checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2 within budget", idx); end
    repeat (2) @(negedge clk);
    pc_valid = 1'b1;
    pc_in    = 32'h18;
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", pc_ready); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %b want 1", instr_valid); end
    checks++; if (instr_pc !== 32'h10) begin errors++; $display("FAIL bp_head_pc: got %h want 10", instr_pc); end
    checks++; if (instr_out !== 32'hAAAA0010) begin errors++; $display("FAIL bp_head_data: got %h want aaaa0010", instr_out); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b want 0", pc_ready); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_pc: got req %b want 0", imem_req_valid); end
      checks++; if (instr_pc !== 32'h10) begin errors++; $display("FAIL bp_hold_head: got %h want 10", instr_pc); end
    end
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_ready: got %b want 1", pc_ready); end
    checks++; if (instr_pc !== 32'h14) begin errors++; $display("FAIL bp_after_pop_pc: got %h want 14", instr_pc); end
    checks++; if (instr_out !== 32'hAAAA0014) begin errors++; $display("FAIL bp_after_pop_data: got %h want aaaa0014", instr_out); end
    flush       = 1'b1;
    instr_ready = 1'b1;
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready: got %b want 0", pc_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_empties_fifo: got %b want 0", instr_valid); end
  endtask

  task automatic test_flush_wait();
    apply_reset();
    mem_extra    = 2;
    mem_fixed_en = 1'b1;
    mem_fixed    = 32'h0000DEAD;
    pc_valid     = 1'b1;
    pc_in        = 32'h20;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL fw_accept: got %b want 1", pc_ready); end
    @(negedge clk);
    pc_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fw_req: got %b want 1", imem_req_valid); end
    @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fw_in_wait: got req %b want 0", imem_req_valid); end
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fw_discard: got valid %b want 0 (step %0d)", instr_valid, i); end
      checks++; if (pc_ready !== (i >= 2)) begin errors++; $display("FAIL fw_ready: got %b want %b (step %0d)", pc_ready, (i >= 2), i); end
    end
    mem_fixed_en = 1'b0;
  endtask

  task automatic test_flush_req();
    apply_reset();
    imem_req_ready = 1'b0;
    pc_valid       = 1'b1;
    pc_in          = 32'h33;
    @(negedge clk);
    pc_valid = 1'b0;
    flush    = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fr_req_first: got %b want 1", imem_req_valid); end
    checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL fr_addr_align: got %h want 30", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fr_req_held: got %b want 1", imem_req_valid); end
      checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL fr_addr_stable: got %h want 30", imem_addr); end
      checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL fr_busy_ready: got %b want 0", pc_ready); end
    end
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fr_req_at_accept: got %b want 1", imem_req_valid); end
    @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fr_drain_req: got %b want 0", imem_req_valid); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL fr_drain_ready: got %b want 0", pc_ready); end
    @(negedge clk);
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL fr_idle_ready: got %b want 1", pc_ready); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fr_no_push: got %b want 0", instr_valid); end
    @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fr_no_push_late: got %b want 0", instr_valid); end
  endtask

  task automatic test_midop_reset();
    apply_reset();
    instr_ready = 1'b0;
    pc_valid    = 1'b1;
    pc_in       = 32'h40;
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (2) @(negedge clk);
    pc_valid  = 1'b1;
    pc_in     = 32'h44;
    mem_extra = 3;
    #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mr_one_entry: got %b want 1", instr_valid); end
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL mr_entry_pc: got %h want 40", instr_pc); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL mr_second_accept: got %b want 1", pc_ready); end
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mr_in_wait: got req %b want 0", imem_req_valid); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_cleared: got %b want 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mr_req_cleared: got %b want 0", imem_req_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL mr_idle_ready: got %b want 1", pc_ready); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL mr_pc_cleared: got %h want 0", instr_pc); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale_push: got %b want 0", instr_valid); end
    mem_extra   = 0;
    instr_ready = 1'b1;
  endtask

  task automatic test_random();
    ent_t          m_q[$];
    ent_t          e;
    logic          m_busy;
    logic          m_req_pend;
    logic          m_drop;
    logic [AW-1:0] m_pc;
    logic          e_ready;
    logic          e_req;
    logic          do_pop;
    int            npop;
    apply_reset();
    mem_rand   = 1'b1;
    m_busy     = 1'b0;
    m_req_pend = 1'b0;
    m_drop     = 1'b0;
    m_pc       = '0;
    npop       = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      pc_valid       = ($urandom_range(0, 3) != 0);
      pc_in          = $urandom;
      imem_req_ready = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 23) == 0);
      instr_ready    = ($urandom_range(0, 1) == 1);
      mem_extra      = int'($urandom_range(0, 2));
      e_ready = !m_busy && (m_q.size() < DEPTH) && !flush;
      e_req   = m_busy && m_req_pend;
      #1;
      checks++; if (pc_ready !== e_ready) begin errors++; $display("FAIL rnd_pc_ready: cycle %0d got %b want %b", cyc, pc_ready, e_ready); end
      checks++; if (imem_req_valid !== e_req) begin errors++; $display("FAIL rnd_req_valid: cycle %0d got %b want %b", cyc, imem_req_valid, e_req); end
      if (e_req) begin
        checks++; if (imem_addr !== {m_pc[AW-1:2], 2'b00}) begin errors++; $display("FAIL rnd_addr: cycle %0d got %h want %h", cyc, imem_addr, {m_pc[AW-1:2], 2'b00}); end
      end
      checks++; if (instr_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_instr_valid: cycle %0d got %b want %b", cyc, instr_valid, (m_q.size() != 0)); end
      if (m_q.size() != 0) begin
        checks++; if (instr_pc !== m_q[0].pc) begin errors++; $display("FAIL rnd_instr_pc: cycle %0d got %h want %h", cyc, instr_pc, m_q[0].pc); end
        checks++; if (instr_out !== m_q[0].dat) begin errors++; $display("FAIL rnd_instr_out: cycle %0d got %h want %h", cyc, instr_out, m_q[0].dat); end
      end
      #2;
      do_pop = (m_q.size() != 0) && instr_ready;
      if (do_pop) begin
        void'(m_q.pop_front());
        if (!flush) npop++;
      end
      if (imem_rsp_valid) begin
        if (!m_drop && !flush) begin
          e.pc  = m_pc;
          e.dat = imem_rsp_data;
          m_q.push_back(e);
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else if (m_busy && flush) begin
        m_drop = 1'b1;
      end
      if (m_busy && m_req_pend && imem_req_ready) m_req_pend = 1'b0;
      if (flush) m_q.delete();
      if (pc_valid && e_ready) begin
        m_busy     = 1'b1;
        m_req_pend = 1'b1;
        m_pc       = pc_in;
      end
      @(negedge clk);
    end
    pc_valid = 1'b0;
    flush    = 1'b0;
    mem_rand = 1'b0;
    checks++; if (npop < 50) begin errors++; $display("FAIL rnd_activity: got %0d pops want at least 50", npop); end
  endtask

  initial begin
    reset          = 1'b0;
    pc_in          = '0;
    pc_valid       = 1'b0;
    imem_req_ready = 1'b1;
    flush          = 1'b0;
    instr_ready    = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_wait();
    test_flush_req();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the PC register. Accepts one PC per handshake, issues a single-outstanding word read to instruction memory, and buffers each returned {pc, instruction} pair in a small FIFO for the decode stage. A flush input discards in-flight and buffered fetches when a branch redirects the PC.

Parameters:
ADDR_W  32  width of PC and memory address
DATA_W  32  instruction word width
FIFO_DEPTH  2  entries in the output buffer (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
pc_in  in  ADDR_W  PC from PC stage
pc_valid  in  1  pc_in valid
pc_ready  out  1  fetch accepts pc_in this cycle
imem_req_valid  out  1  memory read request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  ADDR_W  read address, {pc[ADDR_W-1:2],2'b00}
imem_rsp_valid  in  1  read data valid (one per accepted request)
imem_rsp_data  in  DATA_W  read data
flush  in  1  discard all fetches (branch redirect)
instr_valid  out  1  instr_out/instr_pc valid to decode
instr_ready  in  1  decode consumes entry
instr_out  out  DATA_W  instruction at FIFO head
instr_pc  out  ADDR_W  PC of instruction at FIFO head

Behaviour:
- Reset (reset clock and clock, reset==0 at posedge clk): state IDLE, FIFO empty, count=0, imem_req_valid=0, instr_valid=0, instr_out=0, instr_pc=0, imem_addr=0. pc_ready=1 in the first cycle after reset deasserts. A reset mid-operation abandons any outstanding request. Memory shares this reset, so no stale response arrives afterwards.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- pc_ready (combinational) = (state==IDLE) && (count<FIFO_DEPTH) && !flush. Checking FIFO space before acceptance reserves a slot for the in-flight word, so a push never overflows.
- IDLE: pc_valid&&pc_ready -> latch aligned address and pc_in, go to REQ. pc_in[1:0] is ignored for the address but preserved in instr_pc.
- REQ: imem_req_valid=1, imem_addr stable until accepted. imem_req_ready -> WAIT (flush that cycle -> DRAIN).
- WAIT: imem_rsp_valid -> push {pc, data}, go to IDLE. A response in the same cycle as acceptance is not allowed; the earliest response is one cycle after acceptance.
- Minimum latency: pc accepted at cycle N, request at N+1 (with ready=1), response at N+2, instr_valid=1 at N+3. Throughput is one instruction per 3 cycles.
- flush in REQ: the request stays asserted until accepted (valid never withdrawn), then the FSM enters DRAIN. flush in WAIT goes to DRAIN. In DRAIN, the next imem_rsp_valid is discarded (no push), then IDLE. A response coinciding with flush in WAIT is discarded, and the FSM goes directly to IDLE.
- flush in any state empties the FIFO at the next edge: count=0, instr_valid=0 next cycle. Flush beats a same-cycle push and pop.
- FIFO: circular buffer with wrapping head/tail pointers. instr_valid=(count!=0). Pop on instr_valid&&instr_ready. Push and pop in the same cycle leave count unchanged and are legal when full. Outputs hold while instr_valid&&!instr_ready.
- imem_rsp_valid in IDLE or REQ is illegal (assertion); the bench never drives it.

Test Plan:
- Reset: hold reset=0 2 cycles, release -> all outputs 0, pc_ready=1; pc_in=0x0 accepted, imem_req_valid=1 with imem_addr=0x0 one cycle later.
- Streaming: PCs 0x0,0x4,0x8 with req_ready=1 and 1-cycle rsp returning 0xAAAA0000+pc, instr_ready=1 -> three instr_valid pulses, instr_pc 0x0/0x4/0x8 in order, each 3 cycles apart.
- Backpressure/full: instr_ready=0, fetch 0x10,0x14 -> count=2, pc_ready=0, further pc_valid ignored; raise instr_ready one cycle -> head 0x10 pops, pc_ready=1 next cycle.
- Flush in WAIT: accept 0x20, flush while waiting, rsp 0xDEAD arrives 3 cycles later -> discarded, instr_valid stays 0, pc_ready=1 after the response.
- Flush in REQ with imem_req_ready=0 for 4 cycles -> imem_req_valid stays 1, addr stable; then DRAIN drops the response, and no push occurs.
- Mid-op reset: reset=0 while in WAIT with 1 FIFO entry -> next cycle instr_valid=0, imem_req_valid=0, state IDLE.
